// File: rtl/rms_sq_accum.sv
// rms_sq_accum: sum of squares of 4-bit samples over contiguous 2^NSAMP_LOG2-sample windows.
// Latency: result lands two edges after the last sample of a window (square reg, then accumulator reg).
// Backpressure: none on the sample stream; an unacked result is overwritten and flagged on overrun_o.
// Optional: define RMS_SQ_PEAK_EN to add peak_o, the largest sample of the last completed window.
module rms_sq_accum #(
    parameter int NSAMP_LOG2  = 10,
    parameter int START_DELAY = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      sync_i,
    input  logic [3:0]                sample_i,
    input  logic                      ack_i,
    output logic [8+NSAMP_LOG2-1:0]   sq_sum_o,
    output logic                      valid_o,
    output logic                      overrun_o,
    output logic                      busy_o
`ifdef RMS_SQ_PEAK_EN
    ,
    output logic [3:0]                peak_o
`endif
);

    localparam int SW = 8 + NSAMP_LOG2;
    // Delay load value; START_DELAY=0 bypasses ARM entirely so the load is unused then.
    localparam logic [3:0] DLY_LOAD = 4'((START_DELAY > 0) ? (START_DELAY - 1) : 0);
    localparam logic [NSAMP_LOG2-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARM, ACCUM} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             dly_q;
    logic [NSAMP_LOG2-1:0]  cnt_q;
    logic                   accept;
    logic [7:0]             sq_w;

    logic [7:0]             sq_q;
    logic                   sq_vld_q, sq_first_q, sq_last_q;
    logic [SW-1:0]          acc_q;
    logic                   acc_last_q;

    assign accept = (state_q == ACCUM) && !sync_i;
    assign sq_w   = {4'd0, sample_i} * {4'd0, sample_i};
    assign busy_o = (state_q != IDLE);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state: sync always restarts; ARM hands over to ACCUM when the delay expires
    always_comb begin
        state_d = state_q;
        if (sync_i)
            state_d = (START_DELAY == 0) ? ACCUM : ARM;
        else if ((state_q == ARM) && (dly_q == 4'd0))
            state_d = ACCUM;
    end

    // Start-delay countdown and free-running in-window sample index
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dly_q <= 4'd0;
            cnt_q <= '0;
        end else if (sync_i) begin
            dly_q <= DLY_LOAD;
            cnt_q <= '0;
        end else begin
            if ((state_q == ARM) && (dly_q != 4'd0)) dly_q <= dly_q - 4'd1;
            if (state_q == ACCUM)                    cnt_q <= cnt_q + NSAMP_LOG2'(1);
        end
    end

    // Stage 1: square the accepted sample and tag window boundaries
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sq_q       <= 8'd0;
            sq_vld_q   <= 1'b0;
            sq_first_q <= 1'b0;
            sq_last_q  <= 1'b0;
        end else begin
            sq_q       <= accept ? sq_w : 8'd0;
            sq_vld_q   <= accept;
            sq_first_q <= accept && (cnt_q == '0);
            sq_last_q  <= accept && (cnt_q == CNT_MAX);
        end
    end

    // Stage 2: accumulate; the first square of a window reloads, sync kills a pending close
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q      <= '0;
            acc_last_q <= 1'b0;
        end else if (sync_i) begin
            acc_last_q <= 1'b0;
        end else begin
            acc_last_q <= sq_vld_q && sq_last_q;
            if (sq_vld_q) acc_q <= sq_first_q ? SW'(sq_q) : (acc_q + SW'(sq_q));
        end
    end

    // Result register with valid/ack handshake and sticky overrun
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sq_sum_o  <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else if (acc_last_q && !sync_i) begin
            sq_sum_o <= acc_q;
            valid_o  <= 1'b1;
            if (valid_o && !ack_i) overrun_o <= 1'b1;
        end else begin
            if (sync_i)            overrun_o <= 1'b0;
            if (valid_o && ack_i)  valid_o   <= 1'b0;
        end
    end

`ifdef RMS_SQ_PEAK_EN
    logic [3:0] sq_smp_q, peak_acc_q;

    // Peak tracking runs alongside the square/accumulate pipeline
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sq_smp_q   <= 4'd0;
            peak_acc_q <= 4'd0;
        end else begin
            sq_smp_q <= accept ? sample_i : 4'd0;
            if (!sync_i && sq_vld_q)
                peak_acc_q <= (sq_first_q || (sq_smp_q > peak_acc_q)) ? sq_smp_q : peak_acc_q;
        end
    end

    // Peak output updates together with sq_sum_o
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                     peak_o <= 4'd0;
        else if (acc_last_q && !sync_i)   peak_o <= peak_acc_q;
    end
`endif

endmodule

// File: tb/tb_rms_sq_accum.sv
// tb_rms_sq_accum: drives two instances (START_DELAY 2 and 0) with shared stimulus.
// Expected values come from a window-arithmetic model over recorded sample history.
// Directed scenarios first, then a randomized run with random ack and sparse sync.
module tb_rms_sq_accum;

    localparam int NL   = 4;
    localparam int NS   = 16;
    localparam int MAXE = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0;
    logic        ack = 1'b0;
    logic [3:0]  sample = 4'd0;

    logic [11:0] sum_a, sum_b;
    logic        vld_a, vld_b, ovr_a, ovr_b, busy_a, busy_b;
`ifdef RMS_SQ_PEAK_EN
    logic [3:0]  pk_a, pk_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rms_sq_accum #(.NSAMP_LOG2(NL), .START_DELAY(2)) u_d2 (
        .clk_i(clk), .rst_n_i(rst_n), .sync_i(sync), .sample_i(sample), .ack_i(ack),
        .sq_sum_o(sum_a), .valid_o(vld_a), .overrun_o(ovr_a), .busy_o(busy_a)
`ifdef RMS_SQ_PEAK_EN
        , .peak_o(pk_a)
`endif
    );

    rms_sq_accum #(.NSAMP_LOG2(NL), .START_DELAY(0)) u_d0 (
        .clk_i(clk), .rst_n_i(rst_n), .sync_i(sync), .sample_i(sample), .ack_i(ack),
        .sq_sum_o(sum_b), .valid_o(vld_b), .overrun_o(ovr_b), .busy_o(busy_b)
`ifdef RMS_SQ_PEAK_EN
        , .peak_o(pk_b)
`endif
    );

    // ---------------- reference model ----------------
    int  smp [MAXE];
    bit  syn [MAXE];
    bit  lastf [2][MAXE];
    int  ecount = 0;
    int  epoch  = 0;
    int  dly [2] = '{2, 0};
    bit  act [2];
    int  start [2];
    int  m_sum [2];
    bit  m_vld [2];
    bit  m_ovr [2];
    int  m_pk [2];

    always @(posedge clk or negedge rst_n) begin
        int e, s, p, v;
        bit res;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                act[i] = 0; m_sum[i] = 0; m_vld[i] = 0; m_ovr[i] = 0; m_pk[i] = 0;
            end
            epoch = ecount;
        end else if (ecount < MAXE) begin
            e = ecount;
            smp[e] = int'(sample);
            syn[e] = sync;
            for (int i = 0; i < 2; i++) begin
                if (sync) begin
                    lastf[i][e] = 0;
                    act[i]      = 1;
                    start[i]    = e + dly[i] + 1;
                    m_ovr[i]    = 0;
                end else begin
                    lastf[i][e] = act[i] && (e >= start[i]) && (((e - start[i]) % NS) == NS - 1);
                end
                res = (e - 2 >= epoch) && lastf[i][e-2] && !syn[e-1] && !syn[e];
                if (res) begin
                    s = 0; p = 0;
                    for (int k = 0; k < NS; k++) begin
                        v = smp[e-2-k];
                        s += v * v;
                        if (v > p) p = v;
                    end
                    if (m_vld[i] && !ack) m_ovr[i] = 1;
                    m_sum[i] = s;
                    m_pk[i]  = p;
                    m_vld[i] = 1;
                end else if (ack && m_vld[i]) begin
                    m_vld[i] = 0;
                end
            end
            ecount++;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cmp_all();
        chk("sum_d2",  32'(sum_a),  m_sum[0]);
        chk("vld_d2",  32'(vld_a),  32'(m_vld[0]));
        chk("ovr_d2",  32'(ovr_a),  32'(m_ovr[0]));
        chk("busy_d2", 32'(busy_a), 32'(act[0]));
        chk("sum_d0",  32'(sum_b),  m_sum[1]);
        chk("vld_d0",  32'(vld_b),  32'(m_vld[1]));
        chk("ovr_d0",  32'(ovr_b),  32'(m_ovr[1]));
        chk("busy_d0", 32'(busy_b), 32'(act[1]));
`ifdef RMS_SQ_PEAK_EN
        chk("peak_d2", 32'(pk_a), m_pk[0]);
        chk("peak_d0", 32'(pk_b), m_pk[1]);
`endif
    endtask

    // One clock: drive inputs just after a falling edge, compare at the next falling edge
    task automatic cyc(input bit s, input int smpv, input bit a);
        sync   = s;
        sample = 4'(smpv);
        ack    = a;
        @(negedge clk);
        cmp_all();
    endtask

    task automatic do_reset();
        sync = 0; ack = 0;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        cmp_all();
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        // Reset state
        chk("rst_sum",  32'(sum_a),  0);
        chk("rst_vld",  32'(vld_a),  0);
        chk("rst_ovr",  32'(ovr_a),  0);
        chk("rst_busy", 32'(busy_a), 0);
        cmp_all();
        rst_n = 1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("idle_busy", 32'(busy_a), 0);

        // Constant full scale: results at edges 20 and 36 (delay 2), 18 for delay 0
        cyc(1, 15, 0);
        chk("sync_busy", 32'(busy_a), 1);
        for (int k = 1; k <= 19; k++) begin
            cyc(0, 15, 0);
            if (k == 17) chk("d0_pre_rise", 32'(vld_b), 0);
            if (k == 18) chk("d0_rise_e18", 32'(vld_b), 1);
        end
        chk("fs_pre_rise", 32'(vld_a), 0);
        cyc(0, 15, 1);
        chk("fs_rise_e20", 32'(vld_a), 1);
        chk("fs_sum1",     32'(sum_a), 3600);
        for (int k = 21; k <= 35; k++) cyc(0, 15, 1);
        chk("fs_acked", 32'(vld_a), 0);
        cyc(0, 15, 0);
        chk("fs_rise_e36", 32'(vld_a), 1);
        chk("fs_sum2",     32'(sum_a), 3600);

        // Ramp 0..15 starting on the first ACCUM cycle
        do_reset();
        cyc(1, 0, 0);
        for (int e = 1; e <= 20; e++) cyc(0, (e - 3) & 15, 0);
        chk("ramp_vld", 32'(vld_a), 1);
        chk("ramp_sum", 32'(sum_a), 1240);
`ifdef RMS_SQ_PEAK_EN
        chk("ramp_peak", 32'(pk_a), 15);
`endif

        // Overrun: ack exactly on a result edge avoids it, an unacked result sets it
        do_reset();
        cyc(1, 3, 0);
        for (int e = 1; e <= 36; e++) begin
            cyc(0, 3, e == 36);
            if (e == 20) chk("ov_sum1", 32'(sum_a), 144);
        end
        chk("ov_ackedge_vld", 32'(vld_a), 1);
        chk("ov_ackedge_ovr", 32'(ovr_a), 0);
        for (int e = 37; e <= 52; e++) cyc(0, 3, 0);
        chk("ov_sum",  32'(sum_a), 144);
        chk("ov_vld",  32'(vld_a), 1);
        chk("ov_flag", 32'(ovr_a), 1);
        cyc(1, 3, 0);
        chk("ov_sync_clr", 32'(ovr_a), 0);

        // Abort at sample 8, fresh window result 20 cycles after the second sync
        do_reset();
        cyc(1, 15, 1);
        for (int e = 1; e <= 10; e++) cyc(0, 15, 1);
        cyc(1, 15, 1);
        for (int e = 12; e <= 30; e++) cyc(0, 15, 0);
        chk("abort_none", 32'(vld_a), 0);
        cyc(0, 15, 0);
        chk("abort_vld", 32'(vld_a), 1);
        chk("abort_sum", 32'(sum_a), 3600);

        // Async reset mid-ACCUM with valid high
        for (int e = 0; e < 6; e++) cyc(0, 15, 0);
        chk("ar_pre_vld", 32'(vld_a), 1);
        #2 rst_n = 0;
        #1;
        chk("ar_sum",  32'(sum_a),  0);
        chk("ar_vld",  32'(vld_a),  0);
        chk("ar_ovr",  32'(ovr_a),  0);
        chk("ar_busy", 32'(busy_a), 0);
        chk("ar_busy_d0", 32'(busy_b), 0);
        @(negedge clk);
        rst_n = 1;
        cmp_all();
        for (int e = 0; e < 30; e++) cyc(0, 15, 0);
        chk("ar_quiet_busy", 32'(busy_a), 0);
        chk("ar_quiet_vld",  32'(vld_a),  0);

        // Randomized run
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 79) == 0, int'($urandom_range(0, 15)), $urandom_range(0, 9) < 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
